// File: rtl/core_config_pkg.sv
// -----------------------------------------------------------------------------
// core_config_pkg
//   Core-wide configuration shared by the execution units.
//
//   XLEN      : architectural register width (dividend / divisor width).
//   XLEN_MIN  : most negative two's-complement XLEN value.
//   neg_mag() : two's-complement magnitude, widened by one bit so the
//               magnitude of XLEN_MIN is representable.
// -----------------------------------------------------------------------------
package core_config_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Magnitude of an XLEN operand as an XLEN+1 bit value. When is_signed is
  // clear the operand is zero-extended unchanged.
  function automatic logic [XLEN:0] neg_mag(input logic [XLEN-1:0] v,
                                            input logic            is_signed);
    logic [XLEN:0] ext;
    ext = {is_signed & v[XLEN-1], v};
    return (is_signed && v[XLEN-1]) ? -ext : ext;
  endfunction

endpackage : core_config_pkg

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Iterative restoring integer divider, one quotient bit per clock.
//   Handles signed (DIV/REM) and unsigned (DIVU/REMU) operation, with
//   RISC-V style results for divide-by-zero and signed overflow.
//
//   Optional feature macro: DIVIDER_EARLY_OUT_EN
//     When defined, divide-by-zero, signed overflow and |X| < |Y| bypass the
//     iterative phase and complete two cycles after start. When undefined,
//     every operation takes XLEN+2 cycles from start to valid.
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   asynchronous, active-high reset
//     start      in   request, only sampled while idle
//     is_signed  in   1 = two's-complement operands, 0 = unsigned
//     X          in   dividend, sampled with start
//     Y          in   divisor, sampled with start
//     busy       out  operation in flight (from cycle after start to valid)
//     valid      out  one-cycle pulse, Q/R valid in that cycle
//     Q          out  quotient (held until the next completion)
//     R          out  remainder (held until the next completion)
// -----------------------------------------------------------------------------
module divider
  import core_config_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] X,
  input  logic [XLEN-1:0] Y,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] Q,
  output logic [XLEN-1:0] R
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  // quo_q starts as |X| and shifts left: dividend bits leave at the top while
  // quotient bits enter at the bottom.
  logic [XLEN-1:0] quo_q,   quo_d;
  logic [XLEN:0]   rem_q,   rem_d;    // partial remainder
  logic [XLEN:0]   div_q,   div_d;    // |Y|
  logic            q_neg_q, q_neg_d;  // quotient must be negated
  logic            r_neg_q, r_neg_d;  // remainder takes the dividend sign
  logic            dz_q,    dz_d;     // divide by zero
  logic            valid_q, valid_d;
  logic [XLEN-1:0] q_q,     q_d;
  logic [XLEN-1:0] r_q,     r_d;

  // ---------------------------------------------------------------------------
  // Operand capture helpers
  // ---------------------------------------------------------------------------
  logic            x_neg, y_neg;
  logic [XLEN:0]   abs_x, abs_y;

  assign x_neg = is_signed & X[XLEN-1];
  assign y_neg = is_signed & Y[XLEN-1];
  assign abs_x = neg_mag(X, is_signed);
  assign abs_y = neg_mag(Y, is_signed);

  // ---------------------------------------------------------------------------
  // One restoring step: shift the next dividend bit into the partial
  // remainder and trial-subtract the divisor. The extra top bit of the
  // subtraction is the borrow; no borrow means the divisor fits.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   rem_shift;
  logic [XLEN+1:0] trial;
  logic            fits;

  assign rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign trial     = {1'b0, rem_shift} - {1'b0, div_q};
  assign fits      = ~trial[XLEN+1];

  // ---------------------------------------------------------------------------
  // Sign fix-up applied in FIX. The partial remainder is always below the
  // divisor magnitude, so its low XLEN bits hold the whole value.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] r_mag;
  logic [XLEN-1:0] q_fix, r_fix;

  assign r_mag = rem_q[XLEN-1:0];
  assign q_fix = dz_q    ? '1 : (q_neg_q ? -quo_q : quo_q);
  assign r_fix = r_neg_q ? -r_mag : r_mag;

  // Top bits that are provably zero by construction.
  logic unused_bits;
  assign unused_bits = ^{rem_q[XLEN], abs_x[XLEN]};

`ifdef DIVIDER_EARLY_OUT_EN
  logic ovf;
  logic early;
  assign ovf   = is_signed && (X == XLEN_MIN) && (Y == '1);
  assign early = (Y == '0) || ovf || (abs_x < abs_y);
`endif

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    valid_d = 1'b0;
    q_d     = q_q;
    r_d     = r_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          div_d   = abs_y;
          q_neg_d = x_neg ^ y_neg;
          r_neg_d = x_neg;
          dz_d    = (Y == '0);
          count_d = '0;
`ifdef DIVIDER_EARLY_OUT_EN
          if (early) begin
            // Overflow: |Y| is 1, so the quotient is |X| with no remainder.
            // Divide by zero and |X| < |Y| leave the dividend as remainder.
            quo_d   = ovf ? abs_x[XLEN-1:0] : '0;
            rem_d   = ovf ? '0 : abs_x;
            state_d = FIX;
          end else begin
            quo_d   = abs_x[XLEN-1:0];
            rem_d   = '0;
            state_d = CALC;
          end
`else
          quo_d   = abs_x[XLEN-1:0];
          rem_d   = '0;
          state_d = CALC;
`endif
        end
      end

      CALC: begin
        rem_d   = fits ? trial[XLEN:0] : rem_shift;
        quo_d   = {quo_q[XLEN-2:0], fits};
        count_d = (count_q == CNT_LAST) ? '0 : count_q + 1'b1;
        if (count_q == CNT_LAST) begin
          state_d = FIX;
        end
      end

      FIX: begin
        q_d     = q_fix;
        r_d     = r_fix;
        valid_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the operand/working registers are reset along with the control
  // state so that nothing observable depends on pre-reset contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      count_q <= count_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      valid_q <= valid_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign valid = valid_q;
  assign Q     = q_q;
  assign R     = r_q;

endmodule : divider

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//   Self-checking bench for divider: directed vector table, randomized
//   operations against an arithmetic reference model, and hand-written
//   sequences for busy-ignore, mid-operation reset and back-to-back starts.
//   Honours DIVIDER_EARLY_OUT_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_divider;
  import core_config_pkg::*;

`ifdef DIVIDER_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  // Latency in rising edges from the accepting edge to the edge after which
  // valid is high.
  localparam int FULL_LAT = XLEN + 1;
  localparam int TIMEOUT  = 200;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            is_signed;
  logic [XLEN-1:0] X;
  logic [XLEN-1:0] Y;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] Q;
  logic [XLEN-1:0] R;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .X         (X),
    .Y         (Y),
    .busy      (busy),
    .valid     (valid),
    .Q         (Q),
    .R         (R)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain 64-bit arithmetic with truncating division.
  // ---------------------------------------------------------------------------
  function automatic longint to_long(input logic [XLEN-1:0] v, input logic s);
    return s ? longint'($signed(v)) : longint'({32'b0, v});
  endfunction

  function automatic void ref_div(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                                  input logic s,
                                  output logic [XLEN-1:0] q, output logic [XLEN-1:0] r);
    longint a, b;
    if (y == '0) begin
      q = '1;
      r = x;
    end else begin
      a = to_long(x, s);
      b = to_long(y, s);
      q = XLEN'(a / b);
      r = XLEN'(a % b);
    end
  endfunction

  function automatic int ref_lat(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                                 input logic s);
    longint ax, ay;
    bit     special;
    ax = to_long(x, s);
    ay = to_long(y, s);
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    special = (y == '0) || (s && x == XLEN_MIN && y == '1) || (ax < ay);
    return (EARLY_OUT && special) ? 1 : FULL_LAT;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs driven at the falling edge, outputs sampled there)
  // ---------------------------------------------------------------------------
  task automatic start_op(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                          input logic s);
    X         = x;
    Y         = y;
    is_signed = s;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Called in the cycle after the accepting edge; n counts further edges.
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        input logic s, input logic [XLEN-1:0] exp_q,
                        input logic [XLEN-1:0] exp_r, input string name);
    int n;
    start_op(x, y, s);
    check({name, ".busy"}, 64'(busy), 64'(1));
    wait_valid(n);
    check({name, ".lat"}, 64'(n), 64'(ref_lat(x, y, s)));
    check({name, ".Q"}, 64'(Q), 64'(exp_q));
    check({name, ".R"}, 64'(R), 64'(exp_r));
    check({name, ".busy_at_valid"}, 64'(busy), 64'(0));
    @(negedge clk);
    check({name, ".pulse"}, 64'(valid), 64'(0));
    check({name, ".hold"}, {Q, R}, {exp_q, exp_r});
  endtask

  typedef struct {
    string           name;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic            s;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t            vecs[$];
    logic [XLEN-1:0] rx, ry, eq, er, cap_q, cap_r;
    logic            rs;
    int              n, vcount;

    vecs.push_back('{"udiv_100_7",   32'd100,        32'd7,          1'b0, 32'd14,       32'd2});
    vecs.push_back('{"sdiv_m7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
    vecs.push_back('{"sdiv_7_m2",    32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD, 32'd1});
    vecs.push_back('{"sdiv_m100_m7", 32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,       32'hFFFF_FFFE});
    vecs.push_back('{"sdiv_by0",     32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF, 32'h1234_5678});
    vecs.push_back('{"udiv_by0",     32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF, 32'h1234_5678});
    vecs.push_back('{"sdiv_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0});
    vecs.push_back('{"udiv_ovf_ops", 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,        32'h8000_0000});
    vecs.push_back('{"udiv_small",   32'd5,          32'd9,          1'b0, 32'd0,        32'd5});

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    X         = '0;
    Y         = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset.outputs", {busy, valid, Q, R}, 66'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].name);
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      rx = $urandom();
      ry = $urandom();
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       ry = '0;
        1:       begin rx = XLEN_MIN; ry = '1; end
        2:       ry = XLEN'($urandom_range(1, 255));
        3:       rx = XLEN'($urandom_range(0, 1000));
        default: ;
      endcase
      ref_div(rx, ry, rs, eq, er);
      run_op(rx, ry, rs, eq, er, $sformatf("rand%0d", i));
    end

    // Second start while busy is ignored: one valid, first result only.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    start_op(32'd9, 32'd3, 1'b0);
    vcount = 0;
    cap_q  = '0;
    cap_r  = '0;
    for (int c = 0; c < 2 * FULL_LAT; c++) begin
      if (valid) begin
        vcount++;
        cap_q = Q;
        cap_r = R;
      end
      @(negedge clk);
    end
    check("busy_ignore.valid_count", 64'(vcount), 64'(1));
    check("busy_ignore.result", {cap_q, cap_r}, {32'd14, 32'd2});

    // Reset mid-operation: no valid, outputs cleared, next op runs normally.
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_reset.outputs", {busy, valid, Q, R}, 66'(0));
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int c = 0; c < 2 * FULL_LAT; c++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("mid_reset.no_valid", 64'(vcount), 64'(0));
    run_op(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, "after_reset");

    // Back-to-back: start in the valid cycle is accepted.
    start_op(32'h0000_FFFF, 32'h10, 1'b0);
    wait_valid(n);
    check("b2b.first", {Q, R}, {32'h0000_0FFF, 32'h0000_000F});
    start_op(32'hFFFF_FFCE, 32'd7, 1'b1);
    check("b2b.busy", 64'(busy), 64'(1));
    wait_valid(n);
    check("b2b.lat", 64'(n), 64'(FULL_LAT));
    check("b2b.second", {Q, R}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_divider
